// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC, runs req/ack instruction fetches and selects the next PC after execute.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          IMEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    output logic [31:0] pc,
    output logic        trap,
    output logic [1:0]  trap_cause
);
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC, S_TRAP} state_t;

    state_t      state, state_n;
    logic [31:0] pc_n, instr_n, target;
    logic [1:0]  cause_n;
    logic [7:0]  cnt, cnt_n;

    assign target = branch_taken ? pc + (branch_offset << 1) : pc + 32'd4;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        instr_n = instr;
        cause_n = trap_cause;
        cnt_n   = cnt;
        case (state)
            S_FETCH: if (!stall) begin
                state_n = S_WAIT;
                cnt_n   = '0;
            end
            // ack beats timeout when both land in the same cycle
            S_WAIT: if (imem_ack) begin
                state_n = S_EXEC;
                instr_n = imem_rdata;
            end else if (cnt == 8'(IMEM_TIMEOUT)) begin
                state_n = S_TRAP;
                cause_n = 2'b10;
            end else begin
                cnt_n = cnt + 8'd1;
            end
            S_EXEC: if (exec_done) begin
                if (target[1:0] != 2'b00) begin
                    state_n = S_TRAP;
                    cause_n = 2'b01;
                end else begin
                    state_n = S_FETCH;
                    pc_n    = target;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_FETCH;
            pc         <= RESET_VECTOR;
            instr      <= '0;
            trap_cause <= 2'b00;
            cnt        <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            instr      <= instr_n;
            trap_cause <= cause_n;
            cnt        <= cnt_n;
        end
    end

    // outputs decode the registered state only
    assign imem_req    = (state == S_WAIT);
    assign imem_addr   = pc;
    assign instr_valid = (state == S_EXEC);
    assign trap        = (state == S_TRAP);
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer.
module tb_pc_sequencer;
    logic        clk = 0, reset = 0, stall = 0, imem_ack = 0, exec_done = 0, branch_taken = 0;
    logic [31:0] imem_rdata = 0, branch_offset = 0;
    logic        imem_req, instr_valid, trap;
    logic [31:0] imem_addr, instr, pc;
    logic [1:0]  trap_cause;

    int checks = 0, failures = 0;
    logic [31:0] m_pc;
    logic [31:0] addr_q[$], instr_q[$];

    pc_sequencer #(.RESET_VECTOR(32'h0), .IMEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .exec_done(exec_done), .branch_taken(branch_taken), .branch_offset(branch_offset),
        .pc(pc), .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 0;
        step();
        reset = 1;
        m_pc = 32'h0;
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_trap", 32'(trap), 0);
        chk("rst_cause", 32'(trap_cause), 0);
    endtask

    task automatic fetch(input int w, input logic [31:0] word);
        int n;
        n = 0;
        addr_q.push_back(m_pc);
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        chk("req_rise", 32'(imem_req), 1);
        chk("imem_addr", imem_addr, addr_q.pop_front());
        repeat (w) step();
        chk("req_held", 32'(imem_req), 1);
        imem_rdata = word;
        imem_ack = 1;
        instr_q.push_back(word);
        step();
        imem_ack = 0;
        imem_rdata = $urandom;
        chk("instr_valid", 32'(instr_valid), 1);
        chk("req_drop", 32'(imem_req), 0);
        chk("instr", instr, instr_q.pop_front());
    endtask

    task automatic exec(input logic tk, input logic [31:0] off);
        logic [31:0] tgt;
        tgt = tk ? m_pc + (off << 1) : m_pc + 32'd4;
        exec_done = 1;
        branch_taken = tk;
        branch_offset = off;
        step();
        exec_done = 0;
        branch_taken = 1'($urandom);
        branch_offset = $urandom;
        if (tgt[1:0] != 2'b00) begin
            chk("mis_trap", 32'(trap), 1);
            chk("mis_cause", 32'(trap_cause), 1);
            chk("mis_pc", pc, m_pc);
        end else begin
            m_pc = tgt;
            chk("next_pc", pc, m_pc);
            chk("exec_valid", 32'(instr_valid), 0);
            chk("exec_trap", 32'(trap), 0);
        end
    endtask

    initial begin
        int n;
        logic any_req;
        reset = 0;
        step();
        do_reset();
        fetch(1, 32'h0000_0013); exec(0, 0);
        fetch(1, 32'h0010_0093); exec(0, 0);
        fetch(1, 32'h0020_8113); exec(0, 0);
        chk("pc_after3", pc, 32'hC);
        fetch(0, 32'h1111_1111); exec(0, 0);
        fetch(0, 32'h2222_2222); exec(1, 32'hFFFF_FFF8);
        fetch(0, 32'h3333_3333); exec(1, 32'h6);
        chk("pc_fwd_branch", pc, 32'hC);
        fetch(2, 32'h4444_4444); exec(1, 32'hFFFF_FFFE);
        fetch(0, 32'h5555_5555); exec(1, 32'h1);
        any_req = 0;
        repeat (6) begin
            any_req |= imem_req | instr_valid;
            step();
        end
        chk("trap_quiet", 32'(any_req), 0);
        chk("trap_sticky", 32'(trap), 1);
        do_reset();
        n = 0;
        while (!imem_req && n < 5) begin step(); n++; end
        n = 0;
        while (imem_req && n < 40) begin step(); n++; end
        chk("timeout_req_cycles", n, 16);
        chk("timeout_trap", 32'(trap), 1);
        chk("timeout_cause", 32'(trap_cause), 2);
        chk("timeout_pc", pc, 32'h0);
        do_reset();
        fetch(15, 32'hCAFE_F00D);
        chk("late_ack_notrap", 32'(trap), 0);
        stall = 1;
        step();
        stall = 0;
        step();
        chk("exec_stall_ignored", 32'(instr_valid), 1);
        stall = 1;
        exec(0, 0);
        any_req = 0;
        repeat (5) begin
            any_req |= imem_req;
            step();
        end
        chk("stall_no_req", 32'(any_req), 0);
        stall = 0;
        chk("stall_drop_req0", 32'(imem_req), 0);
        step();
        chk("stall_release_req", 32'(imem_req), 1);
        fetch(0, 32'h7777_7777); exec(0, 0);
        chk("pc_before_midreset", pc, 32'h8);
        step();
        chk("midwait_req", 32'(imem_req), 1);
        reset = 0;
        step();
        reset = 1;
        chk("midwait_rst_pc", pc, 32'h0);
        chk("midwait_rst_req", 32'(imem_req), 0);
        chk("midwait_rst_valid", 32'(instr_valid), 0);
        chk("midwait_rst_trap", 32'(trap), 0);
        m_pc = 32'h0;
        fetch(0, 32'h8888_8888); exec(1, 32'hFFFF_FFFE);
        chk("pc_top", pc, 32'hFFFF_FFFC);
        fetch(1, 32'h9999_9999); exec(0, 0);
        chk("pc_wrap", pc, 32'h0);
        fetch(0, 32'hAAAA_AAAA);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle fetch/next-PC controller for the single-cycle-per-stage RISC-V core without pipeline. It owns the program counter. It runs instruction-memory fetches with a req/ack handshake and presents the fetched instruction to the execute datapath. When execute reports completion, it selects the next PC: PC+4, or on a taken branch PC + (sign-extended offset << 1). Misaligned branch targets and fetch timeouts are trapped.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
IMEM_TIMEOUT, 15, max cycles waiting for imem_ack before timeout trap (1..255)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
stall  input  1  holds sequencer in FETCH (no new request) while high
imem_req  output  1  instruction fetch request, held until ack
imem_addr  output  32  fetch address, equals pc while imem_req high
imem_ack  input  1  memory returns imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
instr  output  32  latched instruction for execute
instr_valid  output  1  instr valid, held high in EXEC
exec_done  input  1  execute finished current instruction (sampled only in EXEC)
branch_taken  input  1  branch condition true, sampled with exec_done
branch_offset  input  32  sign-extended immediate (pre-shift), sampled with exec_done
pc  output  32  current program counter
trap  output  1  sticky; sequencer halted
trap_cause  output  2  00 none, 01 misaligned target, 10 fetch timeout

Behaviour:
- Reset (reset==0 at posedge): state=FETCH, pc=RESET_VECTOR, instr=0, instr_valid=0, imem_req=0, trap=0, trap_cause=00, timeout counter=0. Reset overrides every state, including mid-handshake and TRAP.
- States: FETCH, WAIT, EXEC, TRAP. Encoding is free.
- FETCH: if stall=1, stay and keep imem_req=0. Otherwise go to WAIT next cycle with imem_req=1 and counter=0. Earliest imem_req is the cycle after reset is released.
- WAIT: imem_req=1, imem_addr=pc. If imem_ack=1: instr<=imem_rdata, instr_valid<=1, imem_req<=0, go to EXEC. Ack in the same cycle req first rises is legal. Without ack, counter increments. When counter reaches IMEM_TIMEOUT with no ack: go to TRAP, trap_cause=10, imem_req<=0. An ack arriving in the timeout cycle wins over timeout.
- stall is ignored outside FETCH.
- EXEC: instr_valid=1, instr stable. On exec_done=1:
  - target = branch_taken ? pc + (branch_offset << 1) : pc + 4.
  - All arithmetic is 32-bit modulo 2^32; wrap-around is silent, e.g. 32'hFFFF_FFFC + 4 = 0.
  - If target[1:0] != 00: go to TRAP, trap_cause=01, pc unchanged.
  - Otherwise pc<=target, instr_valid<=0, go to FETCH.
  - exec_done=0 holds EXEC indefinitely (no timeout).
- TRAP: trap=1, imem_req=0, instr_valid=0. pc holds the address of the faulting instruction (misaligned) or the failed fetch (timeout). Exits only via reset.
- Throughput: minimum 3 cycles per instruction (FETCH, WAIT with immediate ack, EXEC with immediate exec_done).
- imem_ack, exec_done, branch_taken and branch_offset are ignored in states where they are not sampled.
- All outputs are registered; none depend combinationally on inputs.

Test Plan:
- Reset, then 3 instructions each acked after 1 wait cycle, exec_done immediate, branch_taken=0 -> imem_addr sequence 0x0, 0x4, 0x8; pc=0xC after third exec_done; each instr captured exactly.
- At pc=0x10, branch_taken=1, branch_offset=32'hFFFF_FFF8 (-8) -> next imem_addr=0x0 (0x10 - 16); then offset=6 at pc=0x0 -> pc=0xC.
- Branch at pc=0x8 with offset=1 (target 0xA) -> trap=1, trap_cause=01, pc stays 0x8, no further imem_req.
- imem_ack never asserted, IMEM_TIMEOUT=15 -> imem_req high for 16 cycles, then trap=1 and trap_cause=10; ack on the 16th WAIT cycle -> no trap, instr latched.
- stall=1 for 5 cycles in FETCH -> imem_req stays 0 for those cycles and rises the cycle after stall drops; stall toggled during EXEC has no effect.
- reset=0 asserted mid-WAIT and while in TRAP -> next cycle pc=RESET_VECTOR, trap=0, imem_req=0, instr_valid=0; pc=32'hFFFF_FFFC with no branch -> pc wraps to 0x0.
